// File: rtl/uart_rx_capture.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_capture
//  Purpose  : 16x oversampling UART receiver. Data width and parity are
//             selectable at runtime. Accepted bytes are buffered in a FIFO
//             read through a valid/ready port. Frame, parity and overflow
//             errors are reported on sticky flags.
//  Options  : UART_RX_CAPTURE_LINE_EN - line mode. A received 0x0A is not
//             stored. eol_o pulses on a newline, or when MAX_LINE bytes have
//             been stored in the current line.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_capture #(
    parameter int DIV_WIDTH = 16,
    parameter int DEPTH     = 16,
    parameter int MAX_LINE  = 80
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_i,
    input  logic [DIV_WIDTH-1:0]    baud_div_i,
    input  logic [1:0]              data_bits_i,
    input  logic [1:0]              parity_i,
    output logic [7:0]              rdata_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    input  logic                    clear_i,
    output logic                    frame_err_o,
    output logic                    par_err_o,
    output logic                    ovf_o,
    output logic                    eol_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int c_AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_prev;
    logic [DIV_WIDTH-1:0]   r_presc;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [1:0]             r_nbits;
    logic [1:0]             r_par_mode;
    logic [3:0]             r_sub;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par_acc;
    logic                   r_par_bad;

    logic                   w_tick;
    logic                   w_fall;
    logic                   w_par_en;
    logic                   w_stop_samp;
    logic                   w_frame_bad;
    logic                   w_par_fail;
    logic                   w_accept;
    logic                   w_store;
    logic [7:0]             w_data;

    // The divisor counts clocks per sub-bit minus one, so 0 gives one
    // clock per sub-bit (16 clocks per bit).
    assign w_tick      = (r_state != S_IDLE) && (r_presc == r_div);
    assign w_fall      = r_rx_prev & ~r_sync2;
    assign w_par_en    = (r_par_mode == 2'd1) || (r_par_mode == 2'd2);
    assign w_stop_samp = (r_state == S_STOP) && w_tick && (r_sub == 4'hF);
    assign w_frame_bad = w_stop_samp & ~r_sync2;
    assign w_par_fail  = w_stop_samp &  r_sync2 &  r_par_bad;
    assign w_accept    = w_stop_samp &  r_sync2 & ~r_par_bad;

    // Two-flop synchroniser plus the previous sample for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Prescaler producing the 16x sub-bit tick; parked at 0 while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state == S_IDLE)) begin
            r_presc <= '0;
        end else if (r_presc == r_div) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Frame FSM: start-bit qualification, data shift, parity check, stop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_sub      <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_par_acc  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_nbits    <= 2'd3;
            r_par_mode <= 2'd0;
            r_div      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        // Configuration is frozen for the whole frame.
                        r_state    <= S_START;
                        r_sub      <= 4'd0;
                        r_bit_cnt  <= 3'd0;
                        r_shift    <= 8'd0;
                        r_par_acc  <= 1'b0;
                        r_par_bad  <= 1'b0;
                        r_nbits    <= data_bits_i;
                        r_par_mode <= parity_i;
                        r_div      <= baud_div_i;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_sub == 4'd7) begin
                            r_sub <= 4'd0;
                            // A line already high again at mid-start is a glitch.
                            r_state <= r_sync2 ? S_IDLE : S_DATA;
                        end else begin
                            r_sub <= r_sub + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_sub == 4'hF) begin
                            r_sub     <= 4'd0;
                            r_shift   <= {r_sync2, r_shift[7:1]};
                            r_par_acc <= r_par_acc ^ r_sync2;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == ({1'b0, r_nbits} + 3'd4)) begin
                                r_state <= w_par_en ? S_PARITY : S_STOP;
                            end
                        end else begin
                            r_sub <= r_sub + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_sub == 4'hF) begin
                            r_sub     <= 4'd0;
                            r_par_bad <= (r_par_acc ^ r_sync2) != (r_par_mode == 2'd2);
                            r_state   <= S_STOP;
                        end else begin
                            r_sub <= r_sub + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_sub == 4'hF) begin
                            // Back to idle at mid-stop so a following start edge is seen.
                            r_sub   <= 4'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_sub <= r_sub + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Right-justify the received bits; unused MSBs read as zero.
    always_comb begin
        w_data = r_shift;
        case (r_nbits)
            2'd0:    w_data = {3'b000, r_shift[7:3]};
            2'd1:    w_data = {2'b00,  r_shift[7:2]};
            2'd2:    w_data = {1'b0,   r_shift[7:1]};
            default: w_data = r_shift;
        endcase
    end

`ifdef UART_RX_CAPTURE_LINE_EN
    localparam int c_LCW = $clog2(MAX_LINE + 1);
    localparam logic [c_LCW-1:0] c_LINE_LAST = c_LCW'(MAX_LINE - 1);

    logic [c_LCW-1:0] r_line_cnt;
    logic             r_eol;
    logic             w_is_nl;

    assign w_is_nl = (w_data == 8'h0A);
    assign w_store = w_accept & ~w_is_nl;
    assign eol_o   = r_eol;

    // Line length counter and end-of-line pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_line_cnt <= '0;
            r_eol      <= 1'b0;
        end else begin
            r_eol <= 1'b0;
            if (w_accept && w_is_nl) begin
                r_eol      <= 1'b1;
                r_line_cnt <= '0;
            end else if (w_store) begin
                if (r_line_cnt == c_LINE_LAST) begin
                    r_eol      <= 1'b1;
                    r_line_cnt <= '0;
                end else begin
                    r_line_cnt <= r_line_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign w_store = w_accept;
    assign eol_o   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [DEPTH];
    logic [c_AW:0] r_wr;
    logic [c_AW:0] r_rd;
    logic [7:0]  r_rdata;
    logic        r_frame_err;
    logic        r_par_err;
    logic        r_ovf;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [c_AW:0] w_wr_next;
    logic [c_AW:0] w_rd_next;
    logic [7:0]    w_head_next;

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_pop     = ~w_empty & rready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push    = w_store & (~w_full | w_pop);
    assign w_drop    = w_store & w_full & ~w_pop;
    assign w_wr_next = r_wr + {{c_AW{1'b0}}, w_push};
    assign w_rd_next = r_rd + {{c_AW{1'b0}}, w_pop};

    // Head value after this cycle's push/pop, so rdata_o can be a register.
    always_comb begin
        w_head_next = r_mem[w_rd_next[c_AW-1:0]];
        if (w_wr_next == w_rd_next) begin
            w_head_next = 8'd0;
        end else if (w_push && (r_wr == w_rd_next)) begin
            w_head_next = w_data;
        end
    end

    // Storage array write.
    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i && !rst_i) begin
            r_mem[r_wr[c_AW-1:0]] <= w_data;
        end
    end

    // Pointers, registered head data and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_rdata     <= 8'd0;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_wr        <= w_wr_next;
            r_rd        <= w_rd_next;
            r_rdata     <= w_head_next;
            r_frame_err <= r_frame_err | w_frame_bad;
            r_par_err   <= r_par_err   | w_par_fail;
            r_ovf       <= r_ovf       | w_drop;
        end
    end

    assign rdata_o     = r_rdata;
    assign rvalid_o    = ~w_empty;
    assign level_o     = r_wr - r_rd;
    assign frame_err_o = r_frame_err;
    assign par_err_o   = r_par_err;
    assign ovf_o       = r_ovf;

endmodule
`default_nettype wire
